mole_spawner: RTL and testbench
===============================

Name: mole_spawner

Overview:
- Drives the mole interface from the game side: picks a random LED, raises it as a one-hot level, and holds it until the detector reports a result or the mole times out.
- Supplies `active_onehot` to `mole_detector` and consumes that block's `hit_pulse` and `miss_pulse`.
- Inserts a tick-timed gap between moles.
- Clocked from CLOCK_50 and timed by the 1 ms tick from `timer`.

Parameters:
- N_MOLES, 10, number of LEDs/moles; legal range 2..16.
- RNG_W, 5, width of the `rng_value` input.
- GAP_TICKS, 500, ticks with no mole lit between moles; must be >= 1.
- UP_TICKS, 2000, ticks a mole stays lit without a response before timeout; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase pulse.
- enable  in  1  level; game running.
- rng_value  in  RNG_W  free-running random value.
- hit_pulse  in  1  one-cycle pulse from the detector; mole hit.
- miss_pulse  in  1  one-cycle pulse from the detector; wrong press or window expired.
- active_onehot  out  N_MOLES  registered level; currently lit mole, 0 or one-hot.
- spawn_pulse  out  1  one cycle, coincident with the first cycle `active_onehot` is nonzero.
- timeout_pulse  out  1  one cycle when a mole expires unanswered.
- mole_idx  out  4  index of the current or last mole.
- round_count  out  8  moles spawned since reset; saturates at 255.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, `rst_n` = 0):
  - `active_onehot` = 0; `spawn_pulse` = 0; `timeout_pulse` = 0; `mole_idx` = 0; `round_count` = 0; `busy` = 0.
  - State = IDLE; `tick_cnt` = 0.
  - `prev_idx` = N_MOLES (an invalid index, so no repeat avoidance applies on the first pick).
- All outputs are registered.
- State IDLE:
  - `active_onehot` = 0.
  - `enable` = 1 → GAP, loading `tick_cnt` = GAP_TICKS.
- State GAP:
  - On each `tick`, decrement `tick_cnt`.
  - A `tick` while `tick_cnt` == 1 → PICK. The gap is exactly GAP_TICKS ticks.
  - Clock cycles without `tick` do not count.
- State PICK (exactly 1 cycle):
  - `idx` = `rng_value` mod N_MOLES.
  - If `idx` == `prev_idx`, then `idx` = (`idx` + 1) mod N_MOLES.
  - On the exit edge, registered together:
    - `active_onehot` = 1 << `idx`; `mole_idx` = `idx`; `prev_idx` = `idx`;
    - `spawn_pulse` = 1; `round_count` += 1 unless already 255;
    - `tick_cnt` = UP_TICKS; go to UP.
- State UP, per-cycle priority:
  1. `hit_pulse` → clear `active_onehot` on the next edge, go to GAP (reload GAP_TICKS).
  2. `miss_pulse` → same action as hit.
  3. `tick` while `tick_cnt` == 1 → clear `active_onehot`, `timeout_pulse` = 1 for one cycle, go to GAP.
  4. `tick` otherwise → decrement `tick_cnt`.
- Simultaneous events:
  - `hit_pulse` together with `miss_pulse` is treated as a hit.
  - A hit or miss on the same cycle as the final tick suppresses `timeout_pulse`.
- `hit_pulse` / `miss_pulse` outside UP are ignored.
- `enable` = 0 in any state: next edge goes to IDLE with `active_onehot` = 0. No timeout is generated, and `round_count` is held.
- Mid-operation reset: `rst_n` low clears `active_onehot` immediately (no clock edge needed). Releasing reset resumes from IDLE.
- Modulo is combinational on `rng_value` with a constant divisor. The result must be < N_MOLES for every `rng_value` in 0..2^RNG_W-1.
- At most one bit of `active_onehot` is ever set.

Test Plan:
Bench uses N_MOLES=10, GAP_TICKS=3, UP_TICKS=4, `tick` every 4 clocks.
1. Release reset, `enable`=1, `rng_value`=7 → after 3 ticks one PICK cycle, then `active_onehot`=0x080, `spawn_pulse` high 1 cycle, `mole_idx`=7, `round_count`=1.
2. Next mole with `rng_value`=23 → `active_onehot`=0x008, `mole_idx`=3. Then with `prev_idx`=3, `rng_value`=13 → `idx` 4 (`active_onehot`=0x010). Then with `prev_idx`=9, `rng_value`=9 → wraps to `idx` 0 (0x001).
3. In UP, assert `hit_pulse` and `miss_pulse` on the same cycle as the 4th tick → `active_onehot`=0 next cycle, `timeout_pulse` never asserts, state returns to GAP, and the next spawn arrives exactly 3 ticks later.
4. In UP with no response → after 4 ticks `active_onehot`=0 and `timeout_pulse`=1 for exactly one cycle. A `hit_pulse` arriving 2 cycles later has no effect.
5. Drive `enable`=0 mid-UP → `active_onehot`=0 and `busy`=0 on the next edge, `round_count` unchanged. Pull `rst_n` low mid-UP between clock edges → `active_onehot`=0 and `round_count`=0 immediately.
6. Run 260 moles by hit → `round_count` saturates at 255. Sweep `rng_value` 0..31 → `mole_idx` is always < 10 and `active_onehot` is always one-hot.

Source files
------------

// File: rtl/mole_spawner.sv
// Game-side mole generator: waits a tick-timed gap, picks a random LED (no
// immediate repeats), lights it one-hot and clears it on hit, miss or timeout.
module mole_spawner #(
    parameter int N_MOLES   = 10,
    parameter int RNG_W     = 5,
    parameter int GAP_TICKS = 500,
    parameter int UP_TICKS  = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               enable,
    input  logic [RNG_W-1:0]   rng_value,
    input  logic               hit_pulse,
    input  logic               miss_pulse,
    output logic [N_MOLES-1:0] active_onehot,
    output logic               spawn_pulse,
    output logic               timeout_pulse,
    output logic [3:0]         mole_idx,
    output logic [7:0]         round_count,
    output logic               busy
);

    localparam int CNT_MAX = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // One extra bit so prev_idx can hold N_MOLES as the "no previous mole" marker.
    localparam int PIDX_W  = 5;
    localparam int RNG_N   = 2 ** RNG_W;

    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0]  UP_LOAD  = CNT_W'(UP_TICKS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PIDX_W-1:0] IDX_LAST = PIDX_W'(N_MOLES - 1);
    localparam logic [PIDX_W-1:0] IDX_NONE = PIDX_W'(N_MOLES);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        PICK,
        UP
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    tick_cnt_reg, tick_cnt_next;
    logic [PIDX_W-1:0]   prev_idx_reg, prev_idx_next;
    logic [N_MOLES-1:0]  active_reg, active_next;
    logic                spawn_reg, spawn_next;
    logic                timeout_reg, timeout_next;
    logic [3:0]          mole_idx_reg, mole_idx_next;
    logic [7:0]          round_reg, round_next;
    logic                busy_reg;

    logic [PIDX_W-1:0]   mod_table [RNG_N];
    logic [PIDX_W-1:0]   raw_idx;
    logic [PIDX_W-1:0]   pick_idx;
    logic [N_MOLES-1:0]  pick_onehot;

    // Constant-divisor modulo as a small elaboration-time lookup table.
    generate
        for (genvar gi = 0; gi < RNG_N; gi++) begin : g_mod
            assign mod_table[gi] = PIDX_W'(gi % N_MOLES);
        end
    endgenerate

    assign raw_idx  = mod_table[rng_value];
    assign pick_idx = (raw_idx != prev_idx_reg) ? raw_idx :
                      (raw_idx == IDX_LAST)     ? '0 : raw_idx + PIDX_W'(1);

    generate
        for (genvar gi = 0; gi < N_MOLES; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == PIDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        prev_idx_next = prev_idx_reg;
        active_next   = active_reg;
        spawn_next    = 1'b0;
        timeout_next  = 1'b0;
        mole_idx_next = mole_idx_reg;
        round_next    = round_reg;

        if (!enable) begin
            state_next  = IDLE;
            active_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    active_next   = '0;
                    state_next    = GAP;
                    tick_cnt_next = GAP_LOAD;
                end
                GAP: begin
                    if (tick) begin
                        if (tick_cnt_reg == CNT_ONE) begin
                            state_next = PICK;
                        end else begin
                            tick_cnt_next = tick_cnt_reg - CNT_ONE;
                        end
                    end
                end
                PICK: begin
                    active_next   = pick_onehot;
                    mole_idx_next = pick_idx[3:0];
                    prev_idx_next = pick_idx;
                    spawn_next    = 1'b1;
                    if (round_reg != 8'hFF) begin
                        round_next = round_reg + 8'd1;
                    end
                    tick_cnt_next = UP_LOAD;
                    state_next    = UP;
                end
                UP: begin
                    // A response on the final tick wins over the timeout.
                    if (hit_pulse || miss_pulse) begin
                        active_next   = '0;
                        state_next    = GAP;
                        tick_cnt_next = GAP_LOAD;
                    end else if (tick) begin
                        if (tick_cnt_reg == CNT_ONE) begin
                            active_next   = '0;
                            timeout_next  = 1'b1;
                            state_next    = GAP;
                            tick_cnt_next = GAP_LOAD;
                        end else begin
                            tick_cnt_next = tick_cnt_reg - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_next  = IDLE;
                    active_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            prev_idx_reg <= IDX_NONE;
            active_reg   <= '0;
            spawn_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            mole_idx_reg <= '0;
            round_reg    <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            prev_idx_reg <= prev_idx_next;
            active_reg   <= active_next;
            spawn_reg    <= spawn_next;
            timeout_reg  <= timeout_next;
            mole_idx_reg <= mole_idx_next;
            round_reg    <= round_next;
            busy_reg     <= (state_next != IDLE);
        end
    end

    assign active_onehot = active_reg;
    assign spawn_pulse   = spawn_reg;
    assign timeout_pulse = timeout_reg;
    assign mole_idx      = mole_idx_reg;
    assign round_count   = round_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_mole_spawner.sv
// Randomized scoreboard bench for mole_spawner: a stimulus thread queues the
// expected spawns/endings from a simple pick model, a negedge monitor checks them.
module tb_mole_spawner;

    localparam int N     = 10;
    localparam int RW    = 5;
    localparam int GAP   = 3;
    localparam int UP    = 4;

    localparam int END_OK = 0;
    localparam int END_TO = 1;
    localparam int END_AB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          tick = 1'b0;
    logic          enable = 1'b0;
    logic [RW-1:0] rng_value = '0;
    logic          hit_pulse = 1'b0;
    logic          miss_pulse = 1'b0;
    logic [N-1:0]  active_onehot;
    logic          spawn_pulse;
    logic          timeout_pulse;
    logic [3:0]    mole_idx;
    logic [7:0]    round_count;
    logic          busy;

    mole_spawner #(
        .N_MOLES(N), .RNG_W(RW), .GAP_TICKS(GAP), .UP_TICKS(UP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .rng_value(rng_value), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .active_onehot(active_onehot), .spawn_pulse(spawn_pulse),
        .timeout_pulse(timeout_pulse), .mole_idx(mole_idx),
        .round_count(round_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int round;
    } spawn_t;

    spawn_t sq[$];
    int     eq[$];
    int     passed = 0;
    int     total = 0;
    int     prev_m = N;
    int     round_m = 0;
    int     cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic budget_fail(input string name);
        total++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // Reference pick rule: rng mod N, bumped by one (wrapping) if it repeats.
    task automatic expect_spawn(input int rng, input int end_kind);
        spawn_t s;
        int e;
        e = rng % N;
        if (e == prev_m) e = (e + 1) % N;
        prev_m = e;
        if (round_m < 255) round_m++;
        s.idx = e;
        s.round = round_m;
        sq.push_back(s);
        if (end_kind >= 0) eq.push_back(end_kind);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        tick = (cyc % 4 == 0);
        hit_pulse = 1'b0;
        miss_pulse = 1'b0;
    endtask

    task automatic wait_spawn(output bit ok);
        int guard;
        guard = 0;
        while (active_onehot == '0 && guard < 100) begin
            cycle();
            guard++;
        end
        ok = (active_onehot != '0);
        if (!ok) budget_fail("wait_spawn");
    endtask

    // mode: 0 none (timeout), 1 hit, 2 miss, 3 hit+miss. ph=0 respond on the
    // j-th UP tick cycle, ph=1 respond on a non-tick cycle after j ticks.
    task automatic run_mole(input int rng, input int mode, input int j, input bit ph);
        bit ok;
        bit done;
        int upt;
        int guard;
        expect_spawn(rng, (mode == 0) ? END_TO : END_OK);
        rng_value = RW'(rng);
        wait_spawn(ok);
        if (ok) begin
            upt = 0;
            done = 1'b0;
            guard = 0;
            while (active_onehot != '0 && guard < 100) begin
                if (tick) upt++;
                if (mode != 0 && !done && upt == j && (ph ? !tick : tick)) begin
                    hit_pulse = mode[0];
                    miss_pulse = mode[1];
                    done = 1'b1;
                end
                cycle();
                guard++;
            end
            if (active_onehot != '0) budget_fail("wait_clear");
            if (mode == 0) begin
                cycle();
                cycle();
                hit_pulse = 1'b1;
                cycle();
            end
        end
    endtask

    // Monitor: pops expectations whenever a spawn or a mole clearing is seen.
    int     gap_t = 0;
    int     up_t = 0;
    int     prev_act = 0;
    spawn_t ms;
    int     me;

    always @(negedge clk) begin
        if (!rst_n) begin
            gap_t = 0;
            up_t = 0;
            prev_act = 0;
        end else begin
            chk("onehot", int'($countones(active_onehot) <= 1), 1);
            if (active_onehot != '0 && prev_act == 0)
                chk("spawn_with_rise", int'(spawn_pulse), 1);
            if (spawn_pulse) begin
                chk("spawn_first_cycle", int'(prev_act == 0), 1);
                if (sq.size() == 0) begin
                    budget_fail("spawn_unexpected");
                end else begin
                    ms = sq.pop_front();
                    chk("mole_idx", int'(mole_idx), ms.idx);
                    chk("idx_range", int'(mole_idx < 4'(N)), 1);
                    chk("active_onehot", int'(active_onehot), 1 << ms.idx);
                    chk("round_count", int'(round_count), ms.round);
                    chk("gap_ticks", gap_t, GAP);
                end
                gap_t = 0;
                up_t = 0;
            end
            if (prev_act != 0 && active_onehot == '0) begin
                if (eq.size() == 0) begin
                    budget_fail("clear_unexpected");
                end else begin
                    me = eq.pop_front();
                    chk("timeout_pulse", int'(timeout_pulse), (me == END_TO) ? 1 : 0);
                    if (me == END_TO) chk("up_ticks", up_t, UP);
                    if (me == END_OK) chk("up_ticks_max", int'(up_t <= UP), 1);
                end
            end else begin
                chk("no_stray_timeout", int'(timeout_pulse), 0);
            end
            if (tick && active_onehot != '0) up_t++;
            if (tick && busy && active_onehot == '0) gap_t++;
            if (!busy) gap_t = 0;
            prev_act = int'(active_onehot);
        end
    end

    initial begin
        bit ok;
        int mode;
        int j;
        bit ph;
        int last;
        int rsave;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_active", int'(active_onehot), 0);
        chk("rst_spawn", int'(spawn_pulse), 0);
        chk("rst_timeout", int'(timeout_pulse), 0);
        chk("rst_mole_idx", int'(mole_idx), 0);
        chk("rst_round", int'(round_count), 0);
        chk("rst_busy", int'(busy), 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        enable = 1'b1;

        // Directed picks, including repeat avoidance and its wrap to 0.
        run_mole(7, 1, 1, 1'b0);
        run_mole(23, 2, 2, 1'b1);
        run_mole(13, 1, 0, 1'b1);
        run_mole(9, 1, 3, 1'b0);
        run_mole(9, 1, 1, 1'b1);
        // Hit and miss together on the final UP tick: no timeout.
        run_mole(5, 3, UP, 1'b0);
        // Unanswered mole times out, then a late stray hit.
        run_mole(2, 0, 0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            mode = $urandom_range(0, 3);
            ph = 1'($urandom_range(0, 1));
            if (mode == 0) j = 0;
            else if (ph) j = $urandom_range(0, UP - 1);
            else j = $urandom_range(1, UP);
            run_mole($urandom_range(0, 31), mode, j, ph);
        end

        // Disable mid-UP.
        rsave = $urandom_range(0, 31);
        expect_spawn(rsave, END_AB);
        rng_value = RW'(rsave);
        wait_spawn(ok);
        cycle();
        enable = 1'b0;
        cycle();
        chk("dis_active", int'(active_onehot), 0);
        chk("dis_busy", int'(busy), 0);
        chk("dis_round", int'(round_count), round_m);
        enable = 1'b1;

        for (int k = 0; k < 260; k++) run_mole($urandom_range(0, 31), 1, 0, 1'b1);
        chk("round_sat", int'(round_count), 255);

        for (int k = 0; k < 32; k++) run_mole(k, 1, 0, 1'b1);

        // Asynchronous reset mid-UP.
        expect_spawn(4, -1);
        rng_value = RW'(4);
        wait_spawn(ok);
        last = prev_m;
        cycle();
        cycle();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_active", int'(active_onehot), 0);
        chk("arst_round", int'(round_count), 0);
        chk("arst_busy", int'(busy), 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        prev_m = N;
        round_m = 0;
        // Same index as before reset: no repeat avoidance after reset.
        run_mole(last, 1, 2, 1'b0);
        run_mole(last, 0, 0, 1'b0);

        repeat (4) cycle();
        chk("spawn_queue_empty", sq.size(), 0);
        chk("end_queue_empty", eq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

endmodule
